// File: rtl/video_shifter_p.sv
// video_shifter_p: prefetching memory-word to RGB pixel serializer with
// 1 bpp mono / 2 bpp palette modes and a sticky underrun flag.
module video_shifter_p #(
    parameter int          DATA_W         = 16,
    parameter int          ACTIVE_W       = 512,
    parameter int          WORDS_PER_LINE = ACTIVE_W / DATA_W,
    parameter logic [11:0] PAL_RESET      = 12'b100_010_001_000
) (
    input  logic              clk,
    input  logic              res,
    input  logic              line_start,
    input  logic              active,
    input  logic              color,
    input  logic              pal_we,
    input  logic [11:0]       pal_wdata,
    output logic              fetch_req,
    input  logic              fetch_ack,
    input  logic [DATA_W-1:0] fetch_data,
    output logic              R,
    output logic              G,
    output logic              B,
    output logic              underrun
);
    localparam int CW = $clog2(WORDS_PER_LINE + 1);
    localparam int PW = $clog2(DATA_W);
    localparam logic [CW-1:0] WPL = CW'(WORDS_PER_LINE);
    localparam logic [PW-1:0] POS_LAST = PW'(DATA_W - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state;
    logic [DATA_W-1:0] buf_data, shiftreg, cur, nxt;
    logic              buf_full, mode, phase, armed, live, act_d;
    logic [CW-1:0]     req_count, load_count;
    logic [PW-1:0]     pos;
    logic [11:0]       palette;
    logic              ack_v, first, go, slot, bypass, ph, can_req;
    logic [2:0]        rgb, pal_px;

    // armed: line_start seen, waiting for the rising edge of active;
    // live: inside a started line. Both stay low after res so the line stays black.
    always_comb begin
        ack_v   = fetch_ack && fetch_req;
        first   = armed && active && !act_d;
        go      = active && (first || live);
        slot    = go && pos == '0 && load_count < WPL;
        bypass  = slot && !buf_full && ack_v;
        cur     = !slot ? shiftreg : buf_full ? buf_data : ack_v ? fetch_data : '0;
        ph      = phase && !slot;
        nxt     = !mode ? cur >> 1 : ph ? cur >> 2 : cur;
        pal_px  = cur[1:0] == 2'd3 ? palette[11:9] : cur[1] ? palette[8:6] :
                  cur[0] ? palette[5:3] : palette[2:0];
        rgb     = (!go || line_start) ? 3'b000 : !mode ? {3{cur[0]}} : pal_px;
        can_req = (armed || live) && (!buf_full || slot) && req_count < WPL && load_count < WPL;
    end

    always_ff @(posedge clk) begin
        if (res || line_start) begin
            state     <= IDLE;
            fetch_req <= 1'b0;
        end else if (state == IDLE) begin
            if (can_req) begin
                state     <= REQ;
                fetch_req <= 1'b1;
            end
        end else if (fetch_ack) begin
            state     <= IDLE;
            fetch_req <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            {R, G, B}  <= 3'b000;
            underrun   <= 1'b0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            shiftreg   <= '0;
            req_count  <= '0;
            load_count <= '0;
            mode       <= 1'b0;
            phase      <= 1'b0;
            armed      <= 1'b0;
            live       <= 1'b0;
            pos        <= '0;
            act_d      <= 1'b0;
            palette    <= PAL_RESET;
        end else begin
            act_d     <= active;
            {R, G, B} <= rgb;
            if (pal_we) palette <= pal_wdata;
            if (line_start) begin
                mode       <= color;
                buf_full   <= 1'b0;
                req_count  <= '0;
                load_count <= '0;
                underrun   <= 1'b0;
                armed      <= 1'b1;
                live       <= 1'b0;
                pos        <= '0;
                phase      <= 1'b0;
                shiftreg   <= '0;
            end else begin
                if (first) begin
                    armed <= 1'b0;
                    live  <= 1'b1;
                end
                if (go) begin
                    shiftreg <= nxt;
                    phase    <= mode && !ph;
                    pos      <= pos == POS_LAST ? '0 : pos + 1'b1;
                end
                if (slot) load_count <= load_count + 1'b1;
                if (slot && !buf_full && !ack_v) underrun <= 1'b1;
                if (ack_v) req_count <= req_count + 1'b1;
                // a late word lands in the buffer and serves the next slot
                buf_full <= (ack_v && !bypass) || (buf_full && !slot);
                if (ack_v && !bypass) buf_data <= fetch_data;
            end
        end
    end
endmodule

// File: tb/tb_video_shifter_p.sv
// tb_video_shifter_p: directed line scenarios captured per clock, then
// checked against a table of hand-computed probes.
module tb_video_shifter_p;
    localparam int AW = 512;
    localparam int NW = 32;
    localparam int NL = 7;
    localparam int NC = AW + 2;

    logic        clk = 1'b0;
    logic        res, line_start, active, color, pal_we;
    logic [11:0] pal_wdata;
    logic        fetch_req, fetch_ack;
    logic [15:0] fetch_data;
    logic        R, G, B, underrun;

    logic [15:0] words [NW];
    int          dly [NW];
    int          widx, wcnt, acks;
    logic [2:0]  cap [NL][NC];
    logic        ur [NL][NC];
    logic        rq [NL][NC];
    int          acks_line [NL];
    int          passed = 0;
    int          total = 0;
    int          seen;

    typedef struct { int kind; int ln; int idx; int exp; } vec_t;
    vec_t vt [$];

    video_shifter_p dut (
        .clk(clk), .res(res), .line_start(line_start), .active(active),
        .color(color), .pal_we(pal_we), .pal_wdata(pal_wdata),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .R(R), .G(G), .B(B), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // memory: acks word widx once fetch_req has been high for dly[widx] clocks
    initial begin
        fetch_ack = 1'b0; fetch_data = '0; widx = 0; wcnt = 0; acks = 0;
        forever begin
            @(posedge clk); #2;
            if (res || line_start) begin
                fetch_ack = 1'b0; widx = 0; wcnt = 0; acks = 0;
            end else if (fetch_ack) begin
                fetch_ack = 1'b0; widx++; wcnt = 0; acks++;
            end else if (fetch_req && widx < NW) begin
                if (wcnt >= dly[widx]) begin
                    fetch_ack = 1'b1; fetch_data = words[widx];
                end else wcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic add(input int k, input int l, input int i, input int e);
        vt.push_back('{k, l, i, e});
    endtask

    task automatic fill(input logic [15:0] w, input int d);
        for (int k = 0; k < NW; k++) begin
            words[k] = w;
            dly[k] = d;
        end
    endtask

    // index i is the i-th clock from the first active clock; outputs sampled at its start
    task automatic run_line(input int ln, input logic col, input int pal_at, input int flip_at, input int res_at);
        tick();
        line_start = 1'b1;
        color = col;
        tick();
        line_start = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < NC; i++) begin
            tick();
            cap[ln][i] = {R, G, B};
            ur[ln][i]  = underrun;
            rq[ln][i]  = fetch_req;
            active = i < AW;
            pal_we = i == pal_at;
            res    = i == res_at;
            if (i == flip_at) color = ~color;
        end
        repeat (3) tick();
        acks_line[ln] = acks;
    endtask

    initial begin
        res = 1'b1; line_start = 1'b0; active = 1'b0; color = 1'b0; pal_we = 1'b0;
        pal_wdata = 12'b111_000_000_000;
        fill(16'h0000, 1);
        // kind 0 = {R,G,B}, 1 = underrun, 2 = fetch_req
        add(0,0,0,0); add(0,0,1,7); add(0,0,2,0); add(0,0,16,0); add(0,0,17,0); add(0,0,31,0);
        add(0,0,32,7); add(0,0,37,7); add(0,0,41,0); add(0,0,512,7); add(0,0,513,0); add(1,0,513,0);
        add(0,1,1,0); add(0,1,2,0); add(0,1,3,1); add(0,1,4,1); add(0,1,5,2); add(0,1,7,4);
        add(0,1,8,4); add(0,1,9,0); add(0,1,17,4); add(0,1,113,2); add(0,1,114,2);
        add(0,2,1,7); add(0,2,17,7); add(1,2,32,0); add(1,2,33,1); add(0,2,33,0); add(0,2,48,0);
        add(0,2,49,7); add(0,2,50,7); add(0,2,51,0); add(0,2,67,7); add(0,2,68,0); add(1,2,513,1);
        add(1,3,0,0); add(0,3,33,7); add(0,3,34,0); add(0,3,35,7); add(1,3,34,0); add(0,3,49,7);
        add(0,3,50,0); add(1,3,513,0);
        add(0,4,1,4); add(0,4,200,4); add(0,4,201,4); add(0,4,202,7); add(0,4,400,7);
        add(0,5,200,7); add(0,5,201,0); add(1,5,201,0); add(2,5,201,0);
        add(0,6,1,4); add(0,6,511,4);

        repeat (3) tick();
        chk("reset_rgb", int'({R, G, B}), 0);
        chk("reset_req", int'(fetch_req), 0);
        chk("reset_underrun", int'(underrun), 0);
        res = 1'b0;
        active = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if ({R, G, B} != 3'b000 || fetch_req) seen = 1;
        end
        active = 1'b0;
        chk("quiet_before_line_start", seen, 0);

        fill(16'h00F0, 1); words[0] = 16'h0001; words[1] = 16'h8000; words[31] = 16'h8000;
        run_line(0, 1'b0, -1, -1, -1);
        fill(16'h0000, 1); words[0] = 16'h00E4; words[1] = 16'h0003; words[7] = 16'h0002;
        run_line(1, 1'b1, -1, 100, -1);
        fill(16'h0001, 1); words[2] = 16'h0003; words[3] = 16'h0007; dly[2] = 20;
        run_line(2, 1'b0, -1, -1, -1);
        fill(16'h0001, 1); words[2] = 16'h0005; dly[2] = 15;
        run_line(3, 1'b0, -1, -1, -1);
        fill(16'hFFFF, 1);
        run_line(4, 1'b1, 200, -1, -1);
        run_line(5, 1'b0, -1, -1, 200);
        run_line(6, 1'b1, -1, -1, -1);

        foreach (vt[n]) begin
            int got;
            got = vt[n].kind == 0 ? int'(cap[vt[n].ln][vt[n].idx]) :
                  vt[n].kind == 1 ? int'(ur[vt[n].ln][vt[n].idx]) : int'(rq[vt[n].ln][vt[n].idx]);
            chk($sformatf("line%0d_kind%0d_clk%0d", vt[n].ln, vt[n].kind, vt[n].idx), got, vt[n].exp);
        end

        chk("acks_mono", acks_line[0], 32);
        chk("acks_late", acks_line[2], 32);
        chk("acks_bypass", acks_line[3], 32);
        seen = 0;
        for (int i = 201; i < NC; i++) if (cap[5][i] != 3'b000) seen = 1;
        chk("black_after_reset", seen, 0);
        seen = 0;
        for (int i = 201; i < NC; i++) if (rq[5][i]) seen = 1;
        chk("no_req_after_reset", seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
